booth_multiplier_seq: RTL and testbench

//  Sequential signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH two's complement.

---
 rtl/booth_multiplier_seq_pkg.sv | 26 ++
 rtl/booth_multiplier_seq_addsub.sv | 38 +++
 rtl/booth_multiplier_seq.sv | 119 +++++++++++
 tb/tb_booth_multiplier_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/booth_multiplier_seq_pkg.sv
// Shared definitions for the sequential radix-2 Booth multiplier:
// FSM state encodings, Booth operation codes and the recoding helper.
package booth_multiplier_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2
    } op_t;

    // Radix-2 Booth recoding of the current multiplier bit pair {Q[0], Qm1}.
    function automatic op_t booth_op(input logic q0, input logic qm1);
        case ({q0, qm1})
            2'b01:   return OP_ADD;
            2'b10:   return OP_SUB;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_addsub.sv
// Combinational (W+1)-bit add/subtract of the Booth accumulator and multiplicand.
// Subtraction is formed as acc + ~m + 1, with the +1 entering as a carry-in.
module booth_addsub_stage
    import booth_multiplier_seq_pkg::*;
#(
    parameter int W = 4
) (
    input  op_t                logic_op,
    input  logic signed [W:0]  acc,
    input  logic signed [W:0]  m,
    output logic signed [W:0]  sum
);

    logic        [W:0] operand;
    logic              carry_in;

    // Select the second operand and carry-in for the requested Booth operation.
    always_comb begin
        operand  = '0;
        carry_in = 1'b0;
        case (logic_op)
            OP_ADD: begin
                operand  = m;
                carry_in = 1'b0;
            end
            OP_SUB: begin
                operand  = ~m;
                carry_in = 1'b1;
            end
            default: begin
                operand  = '0;
                carry_in = 1'b0;
            end
        endcase
        sum = acc + operand + {{W{1'b0}}, carry_in};
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential signed radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH.
// One add/sub-and-shift step per cycle; start/busy/done handshake; P holds
// the last product until the next accepted start completes.
module booth_multiplier_seq
    import booth_multiplier_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic signed [WIDTH-1:0]     A,
    input  logic signed [WIDTH-1:0]     B,
    output logic                        busy,
    output logic                        done,
    output logic signed [2*WIDTH-1:0]   P
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    state_t                    state;
    state_t                    state_next;
    logic signed [WIDTH:0]     m;
    logic signed [WIDTH:0]     acc;
    logic        [WIDTH-1:0]   q;
    logic                      qm1;
    logic        [CNT_W-1:0]   cnt;
    logic signed [WIDTH:0]     sum;
    logic                      load;
    logic                      step;
    logic                      last;
    op_t                       op;

    assign op   = booth_op(q[0], qm1);
    assign last = (cnt == CNT_W'(1));

    booth_addsub_stage #(
        .W        (WIDTH)
    ) u_addsub (
        .logic_op (op),
        .acc      (acc),
        .m        (m),
        .sum      (sum)
    );

    // Next-state decode and handshake outputs; start only counts outside RUN.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        load       = 1'b0;
        step       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (start) begin
                    load       = 1'b1;
                    state_next = ST_RUN;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand capture, add/sub-and-shift step, and product latch on the final step.
    always_ff @(posedge clk) begin
        if (reset) begin
            m   <= '0;
            acc <= '0;
            q   <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
            P   <= '0;
        end else if (load) begin
            m   <= {A[WIDTH-1], A};
            acc <= '0;
            q   <= B;
            qm1 <= 1'b0;
            cnt <= CNT_W'(WIDTH);
        end else if (step) begin
            // Arithmetic shift right of {sum, q, qm1}.
            acc <= {sum[WIDTH], sum[WIDTH:1]};
            q   <= {sum[0], q[WIDTH-1:1]};
            qm1 <= q[0];
            cnt <= cnt - CNT_W'(1);
            if (last) begin
                // Post-shift {acc[WIDTH-1:0], q}; the extra accumulator bit is dropped.
                P <= {sum[WIDTH:0], q[WIDTH-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq at WIDTH=4.
module tb_booth_multiplier_seq;

    localparam int WIDTH = 4;

    logic                      clk;
    logic                      reset;
    logic                      start;
    logic signed [WIDTH-1:0]   A;
    logic signed [WIDTH-1:0]   B;
    logic                      busy;
    logic                      done;
    logic signed [2*WIDTH-1:0] P;

    int n_checks;
    int n_fail;

    booth_multiplier_seq #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .P     (P)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start pulse and wait (bounded) for done; lat counts edges after acceptance.
    task automatic run_mul(input int a, input int b, output logic [7:0] prod, output int lat);
        logic [31:0] av;
        logic [31:0] bv;
        av = a;
        bv = b;
        A = av[3:0];
        B = bv[3:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
        end
        prod = P;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        A = '0;
        B = '0;
        tick();
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", done); end
        n_checks++; if (P !== 8'h00) begin n_fail++; $display("FAIL reset_P got %h want 00", P); end
    endtask

    task automatic test_basic();
        int busy_cycles;
        A = 4'sd3;
        B = 4'sd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        busy_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy === 1'b1 && done === 1'b0) busy_cycles++;
            tick();
        end
        n_checks++; if (busy_cycles != 4) begin n_fail++; $display("FAIL basic_busy_cycles got %0d want 4", busy_cycles); end
        n_checks++; if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL basic_done got done=%0b busy=%0b want 1/0", done, busy); end
        n_checks++; if (P !== 8'h0F) begin n_fail++; $display("FAIL basic_P got %h want 0f", P); end
        tick();
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got %0b want 0", done); end
        tick();
        tick();
        n_checks++; if (P !== 8'h0F) begin n_fail++; $display("FAIL basic_P_hold got %h want 0f", P); end
    endtask

    task automatic test_corners();
        int          va [4] = '{-8, -8, 0, -1};
        int          vb [4] = '{-8,  7, -1, -1};
        logic [7:0]  ve [4] = '{8'h40, 8'hC8, 8'h00, 8'h01};
        logic [7:0]  prod;
        int          lat;
        for (int i = 0; i < 4; i++) begin
            run_mul(va[i], vb[i], prod, lat);
            n_checks++; if (lat != 4) begin n_fail++; $display("FAIL corner_lat[%0d] got %0d want 4", i, lat); end
            n_checks++; if (prod !== ve[i]) begin n_fail++; $display("FAIL corner_P[%0d] %0d*%0d got %h want %h", i, va[i], vb[i], prod, ve[i]); end
            tick();
        end
    endtask

    task automatic test_start_ignored();
        A = 4'sd2;
        B = 4'sd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        A = 4'sd7;
        B = 4'sd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ignore_busy got %0b want 1", busy); end
        tick();
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %0b want 1", done); end
        n_checks++; if (P !== 8'h06) begin n_fail++; $display("FAIL ignore_P got %h want 06", P); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] va [4] = '{4'sd2, -4'sd3, 4'sd5, -4'sd7};
        logic [3:0] vb [4] = '{4'sd3, 4'sd4, -4'sd5, -4'sd6};
        logic [7:0] ve [4] = '{8'h06, 8'hF4, 8'hE7, 8'h2A};
        int         gap;
        A = va[0];
        B = vb[0];
        start = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (!done && gap < 20);
            n_checks++; if (gap != ((k == 0) ? 4 : 5)) begin n_fail++; $display("FAIL b2b_gap[%0d] got %0d want %0d", k, gap, (k == 0) ? 4 : 5); end
            n_checks++; if (P !== ve[k]) begin n_fail++; $display("FAIL b2b_P[%0d] got %h want %h", k, P, ve[k]); end
            if (k < 3) begin
                A = va[k+1];
                B = vb[k+1];
            end else begin
                start = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_reset_abort();
        int          dones;
        logic [7:0]  prod;
        int          lat;
        A = 4'sd3;
        B = 4'sd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %0b want 0", busy); end
        n_checks++; if (P !== 8'h00) begin n_fail++; $display("FAIL abort_P got %h want 00", P); end
        dones = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dones++;
            tick();
        end
        n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done got %0d pulses want 0", dones); end
        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        tick();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_wins_busy got %0b want 0", busy); end
        run_mul(3, -2, prod, lat);
        n_checks++; if (lat != 4 || prod !== 8'hFA) begin n_fail++; $display("FAIL abort_recover got lat=%0d P=%h want 4/fa", lat, prod); end
        tick();
    endtask

    task automatic test_exhaustive();
        logic [7:0]  prod;
        logic [31:0] expv;
        int          lat;
        for (int a = -8; a < 8; a++) begin
            for (int b = -8; b < 8; b++) begin
                run_mul(a, b, prod, lat);
                expv = a * b;
                n_checks++;
                if (lat != 4 || prod !== expv[7:0]) begin
                    n_fail++;
                    $display("FAIL exhaustive %0d*%0d got P=%h lat=%0d want %h lat=4", a, b, prod, lat, expv[7:0]);
                end
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        test_reset();
        test_basic();
        test_corners();
        test_start_ignored();
        test_back_to_back();
        test_reset_abort();
        test_exhaustive();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
